// File: rtl/neuron_layer_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module      : neuron_layer_ctrl_if
//  Description : Bundle of the layer-control, weight-store, datapath and
//                result-buffer signals around the neuron layer sequencer.
//                The master modport is the sequencer, the slave modport is
//                the surrounding environment.
//  Revision    : 1.0 - initial release
// ============================================================================
interface neuron_layer_ctrl_if #(
    parameter int AW = 4
);
    // layer-level control
    logic          start;
    logic [AW:0]   num_neurons;
    logic [63:0]   x_in;
    logic          busy;
    logic          done;
    logic          err;
    // weight store
    logic          wmem_rd;
    logic [AW-1:0] wmem_addr;
    logic [79:0]   wmem_data;
    // neuron datapath
    logic [63:0]   nu_x;
    logic [63:0]   nu_w;
    logic [15:0]   nu_bias;
    logic          nu_valid;
    logic [31:0]   nu_out;
    // result buffer
    logic          res_wr;
    logic [AW-1:0] res_addr;
    logic [31:0]   res_data;

    modport master (
        input  start, num_neurons, x_in, wmem_data, nu_out,
        output busy, done, err, wmem_rd, wmem_addr,
               nu_x, nu_w, nu_bias, nu_valid, res_wr, res_addr, res_data
    );

    modport slave (
        output start, num_neurons, x_in, wmem_data, nu_out,
        input  busy, done, err, wmem_rd, wmem_addr,
               nu_x, nu_w, nu_bias, nu_valid, res_wr, res_addr, res_data
    );
endinterface
`default_nettype wire

// File: rtl/neuron_layer_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : neuron_layer_ctrl
//  Description : Sequencer for one fully-connected layer on a shared,
//                pipelined 4-input neuron datapath. Latches the input vector,
//                streams one neuron's weights/bias per cycle from the weight
//                store, tracks in-flight neurons with a tag pipeline and
//                writes each result to the result buffer in index order.
//  Revision    : 1.0 - initial release
// ============================================================================
module neuron_layer_ctrl #(
    parameter int AW       = 4,
    parameter int PIPE_LAT = 6
) (
    input  wire logic           clock,
    input  wire logic           reset,
    neuron_layer_ctrl_if.master bus
);

    // Largest legal neuron count, 2**AW, expressed in the count's width.
    localparam logic [AW:0] c_N_MAX = {1'b1, {AW{1'b0}}};

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ISSUE  = 2'd1,
        S_DRAIN  = 2'd2,
        S_FINISH = 2'd3
    } state_t;

    state_t        r_state;
    logic [AW:0]   r_count;
    logic [63:0]   r_nu_x;
    logic          r_wmem_rd;
    logic [AW-1:0] r_wmem_addr;
    logic          r_nu_valid;
    logic [AW-1:0] r_nu_idx;
    logic          r_busy;
    logic          r_done;
    logic          r_err;

    // Each tag entry is {valid, neuron index}; the tail lines up with nu_out.
    logic [AW:0]   r_tag [PIPE_LAT];

    logic          w_count_ok;
    logic          w_last_issue;
    logic          w_tag_any;
    logic          w_pipe_empty;
    logic [AW:0]   w_tail;

    assign w_count_ok   = (bus.num_neurons != '0) && (bus.num_neurons <= c_N_MAX);
    assign w_last_issue = ({1'b0, r_wmem_addr} == (r_count - 1'b1));
    assign w_pipe_empty = !r_nu_valid && !w_tag_any;
    assign w_tail       = r_tag[PIPE_LAT-1];

    // Any neuron still in flight anywhere in the tag pipeline.
    always_comb begin
        w_tag_any = 1'b0;
        for (int i = 0; i < PIPE_LAT; i++) begin
            w_tag_any = w_tag_any | r_tag[i][AW];
        end
    end

    // Layer FSM, issue counter, operand-stage register and status flags.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_count     <= '0;
            r_nu_x      <= '0;
            r_wmem_rd   <= 1'b0;
            r_wmem_addr <= '0;
            r_nu_valid  <= 1'b0;
            r_nu_idx    <= '0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_err       <= 1'b0;
        end else begin
            r_done     <= 1'b0;
            r_err      <= 1'b0;
            // Weight data arrives one cycle after the read, so the operand
            // stage is simply the read strobe and address delayed by one.
            r_nu_valid <= r_wmem_rd;
            r_nu_idx   <= r_wmem_addr;
            case (r_state)
                S_IDLE: begin
                    // A start coinciding with a done pulse is not a new request.
                    if (bus.start && !r_done) begin
                        if (w_count_ok) begin
                            r_nu_x      <= bus.x_in;
                            r_count     <= bus.num_neurons;
                            r_wmem_rd   <= 1'b1;
                            r_wmem_addr <= '0;
                            r_busy      <= 1'b1;
                            r_state     <= S_ISSUE;
                        end else begin
                            r_done <= 1'b1;
                            r_err  <= 1'b1;
                        end
                    end
                end
                S_ISSUE: begin
                    if (w_last_issue) begin
                        r_wmem_rd   <= 1'b0;
                        r_wmem_addr <= '0;
                        r_state     <= S_DRAIN;
                    end else begin
                        r_wmem_addr <= r_wmem_addr + 1'b1;
                    end
                end
                S_DRAIN: begin
                    if (w_pipe_empty) begin
                        r_done  <= 1'b1;
                        r_state <= S_FINISH;
                    end
                end
                S_FINISH: begin
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    // Tag pipeline: shifts every cycle, matching the datapath latency.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < PIPE_LAT; i++) begin
                r_tag[i] <= '0;
            end
        end else begin
            r_tag[0] <= {r_nu_valid, r_nu_idx};
            for (int i = 1; i < PIPE_LAT; i++) begin
                r_tag[i] <= r_tag[i-1];
            end
        end
    end

    assign bus.wmem_rd   = r_wmem_rd;
    assign bus.wmem_addr = r_wmem_addr;
    assign bus.nu_x      = r_nu_x;
    assign bus.nu_w      = r_nu_valid ? bus.wmem_data[63:0]  : '0;
    assign bus.nu_bias   = r_nu_valid ? bus.wmem_data[79:64] : '0;
    assign bus.nu_valid  = r_nu_valid;
    assign bus.res_wr    = w_tail[AW];
    assign bus.res_addr  = w_tail[AW] ? w_tail[AW-1:0] : '0;
    assign bus.res_data  = w_tail[AW] ? bus.nu_out : '0;
    assign bus.busy      = r_busy;
    assign bus.done      = r_done;
    assign bus.err       = r_err;

endmodule
`default_nettype wire
